// File: rtl/micro_sequencer.sv
// Next-state generator for the microprogrammed control unit: selects curState and keeps the incrementer register.
// Optional stall watchdog enabled by defining STALL_WDT_EN.
module micro_sequencer #(
    parameter int SW          = 7,
    parameter int RESET_STATE = 0,
    parameter int FETCH_STATE = 1,
    parameter int WDT_LIMIT   = 255,
    parameter int TRAP_STATE  = 127
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [2:0]    N,
    input  logic [1:0]    S,
    input  logic          Inv,
    input  logic [SW-1:0] CR,
    input  logic          IncRld,
    input  logic          MOC,
    input  logic          Cond,
    input  logic [SW-1:0] EncAddr,
    output logic [SW-1:0] curState,
    output logic          stall_err
);

    logic [SW-1:0] incR;
    logic [SW-1:0] nxt;
    logic          condBit;
    logic          hold;

`ifdef STALL_WDT_EN
    logic [7:0] holdCnt;
    logic       stallErr;
    logic       wdtTrip;
`endif

    always_comb begin
        condBit = 1'b0;
        case (S)
            2'b00:   condBit = MOC;
            2'b01:   condBit = Cond;
            2'b10:   condBit = 1'b0;
            default: condBit = 1'b1;
        endcase
        condBit = condBit ^ Inv;
        hold    = (N == 3'b110) && !condBit;

        nxt = curState;
        case (N)
            3'b000:  nxt = EncAddr;
            3'b001:  nxt = SW'(FETCH_STATE);
            3'b010:  nxt = CR;
            3'b011:  nxt = incR;
            3'b100:  nxt = condBit ? CR : incR;
            3'b101:  nxt = condBit ? CR : EncAddr;
            3'b110:  nxt = condBit ? incR : curState;
            default: nxt = SW'(RESET_STATE);
        endcase

`ifdef STALL_WDT_EN
        // A hold that has already lasted WDT_LIMIT cycles is broken by jumping to the trap state.
        wdtTrip = hold && (holdCnt == 8'(WDT_LIMIT));
        if (wdtTrip) nxt = SW'(TRAP_STATE);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            curState <= SW'(RESET_STATE);
            incR     <= SW'(RESET_STATE + 1);
        end else begin
            curState <= nxt;
            if (IncRld) incR <= nxt + 1'b1;
        end
    end

`ifdef STALL_WDT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            holdCnt  <= 8'd0;
            stallErr <= 1'b0;
        end else if (wdtTrip) begin
            holdCnt  <= 8'd0;
            stallErr <= 1'b1;
        end else if (hold) begin
            holdCnt  <= holdCnt + 8'd1;
        end else begin
            holdCnt  <= 8'd0;
        end
    end

    assign stall_err = stallErr;
`else
    assign stall_err = 1'b0;
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed vector table, reset and long-hold sequences,
// then randomized stimulus against a behavioural model.
module tb_micro_sequencer;

    localparam int SW        = 7;
    localparam int WDT_LIMIT = 255;
    localparam int TRAP      = 127;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    N;
    logic [1:0]    S;
    logic          Inv;
    logic [SW-1:0] CR;
    logic          IncRld;
    logic          MOC;
    logic          Cond;
    logic [SW-1:0] EncAddr;
    logic [SW-1:0] curState;
    logic          stall_err;

    int total = 0;
    int bad   = 0;

    // Reference model state: plain integers updated from the sequencing rules.
    int mCur;
    int mInc;
    int mCnt;
    int mErr;

    typedef struct {
        logic [2:0] n;
        logic [1:0] s;
        logic       inv;
        logic [6:0] cr;
        logic       rld;
        logic       moc;
        logic       cond;
        logic [6:0] enc;
        int         exp;
    } vec_t;

    vec_t vecs[19];

    always #5 clk = ~clk;

    micro_sequencer dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .N        (N),
        .S        (S),
        .Inv      (Inv),
        .CR       (CR),
        .IncRld   (IncRld),
        .MOC      (MOC),
        .Cond     (Cond),
        .EncAddr  (EncAddr),
        .curState (curState),
        .stall_err(stall_err)
    );

    function automatic vec_t mk(int n, int s, int inv, int cr, int rld, int moc, int cond, int enc, int exp);
        vec_t v;
        v.n = 3'(n); v.s = 2'(s); v.inv = 1'(inv); v.cr = 7'(cr);
        v.rld = 1'(rld); v.moc = 1'(moc); v.cond = 1'(cond); v.enc = 7'(enc);
        v.exp = exp;
        return v;
    endfunction

    task automatic modelReset();
        mCur = 0;
        mInc = 1;
        mCnt = 0;
        mErr = 0;
    endtask

    task automatic modelEdge();
        int sources[4];
        int c;
        int nx;
        bit isHold;
        sources[0] = int'(MOC);
        sources[1] = int'(Cond);
        sources[2] = 0;
        sources[3] = 1;
        c = sources[S] ^ int'(Inv);
        case (N)
            3'd0: nx = int'(EncAddr);
            3'd1: nx = 1;
            3'd2: nx = int'(CR);
            3'd3: nx = mInc;
            3'd4: nx = c ? int'(CR) : mInc;
            3'd5: nx = c ? int'(CR) : int'(EncAddr);
            3'd6: nx = c ? mInc : mCur;
            default: nx = 0;
        endcase
        isHold = (N == 3'd6) && (c == 0);
`ifdef STALL_WDT_EN
        if (isHold && mCnt == WDT_LIMIT) begin
            nx   = TRAP;
            mErr = 1;
            mCnt = 0;
        end else if (isHold) begin
            mCnt++;
        end else begin
            mCnt = 0;
        end
`else
        if (isHold) mCnt++;
`endif
        mCur = nx;
        if (IncRld) mInc = (nx + 1) % 128;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        N = v.n; S = v.s; Inv = v.inv; CR = v.cr; IncRld = v.rld;
        MOC = v.moc; Cond = v.cond; EncAddr = v.enc;
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic checkOutput(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    initial begin
        vec_t v;
        reset_n = 1'b0;
        N = 3'd1; S = 2'd0; Inv = 1'b0; CR = '0; IncRld = 1'b0;
        MOC = 1'b0; Cond = 1'b0; EncAddr = '0;
        modelReset();
        #2;
        checkOutput("reset_state", int'(curState), 0);
        checkOutput("reset_err", int'(stall_err), 0);
        @(negedge clk);
        reset_n = 1'b1;

        //           n  s  inv cr  rld moc cond enc exp
        vecs[0]  = mk(1, 0, 0, 0,   0, 0, 0, 0,  1);
        vecs[1]  = mk(0, 0, 0, 0,   1, 0, 0, 20, 20);
        vecs[2]  = mk(3, 0, 0, 0,   0, 0, 0, 0,  21);
        vecs[3]  = mk(4, 1, 0, 50,  0, 0, 1, 0,  50);
        vecs[4]  = mk(4, 1, 1, 50,  0, 0, 1, 0,  21);
        vecs[5]  = mk(2, 0, 0, 9,   1, 0, 0, 0,  9);
        vecs[6]  = mk(6, 0, 0, 0,   0, 0, 0, 0,  9);
        vecs[7]  = mk(6, 0, 0, 0,   0, 0, 0, 0,  9);
        vecs[8]  = mk(6, 0, 0, 0,   0, 0, 0, 0,  9);
        vecs[9]  = mk(6, 0, 0, 0,   0, 1, 0, 0,  10);
        vecs[10] = mk(2, 0, 0, 126, 1, 0, 0, 0,  126);
        vecs[11] = mk(3, 0, 0, 0,   1, 0, 0, 0,  127);
        vecs[12] = mk(3, 0, 0, 0,   1, 0, 0, 0,  0);
        vecs[13] = mk(3, 0, 0, 0,   1, 0, 0, 0,  1);
        vecs[14] = mk(5, 2, 0, 77,  0, 0, 0, 33, 33);
        vecs[15] = mk(5, 3, 0, 77,  0, 0, 0, 33, 77);
        vecs[16] = mk(7, 0, 0, 0,   0, 0, 0, 0,  0);
        vecs[17] = mk(6, 3, 1, 0,   1, 0, 0, 0,  0);
        vecs[18] = mk(3, 0, 0, 0,   0, 0, 0, 0,  1);

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), int'(curState), vecs[i].exp);
        end

        // Asynchronous reset in the middle of a step, away from any clock edge.
        applyStimulus(mk(2, 0, 0, 42, 0, 0, 0, 0, 42));
        checkOutput("pre_reset", int'(curState), 42);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        modelReset();
        #1;
        checkOutput("async_reset", int'(curState), 0);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(mk(3, 0, 0, 0, 0, 0, 0, 0, 1));
        checkOutput("incr_after_reset", int'(curState), 1);
        applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 1));
        checkOutput("fetch_after_reset", int'(curState), 1);

        // Long MOC poll: without the watchdog it never leaves state 9.
        applyStimulus(mk(2, 0, 0, 9, 1, 0, 0, 0, 9));
        for (int i = 0; i < 300; i++) begin
            applyStimulus(mk(6, 0, 0, 0, 0, 0, 0, 0, 9));
            checkOutput("long_hold_state", int'(curState), mCur);
            checkOutput("long_hold_err", int'(stall_err), mErr);
        end

        for (int i = 0; i < 600; i++) begin
            v.n    = ($urandom_range(0, 9) < 2) ? 3'd6 : 3'($urandom_range(0, 6));
            v.s    = 2'($urandom);
            v.inv  = 1'($urandom);
            v.cr   = 7'($urandom);
            v.rld  = 1'($urandom);
            v.moc  = 1'($urandom);
            v.cond = 1'($urandom);
            v.enc  = 7'($urandom);
            v.exp  = 0;
            applyStimulus(v);
            checkOutput("rand_state", int'(curState), mCur);
            checkOutput("rand_err", int'(stall_err), mErr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
